pipe_hazard_ctrl: RTL and testbench

- Central stall/flush scheduler for the 5-stage integer pipeline (PC, IF, ID, EX, MEM, WB).
- Arbitrates three hazard sources into one stall vector and one flush strobe: ID-stage load-use hazards, multi-cycle EX operations, and taken branches/jumps resolved in EX.
- Tracks multi-cycle operations with a timeout watchdog.
- Counts stalled cycles for performance monitoring.

---
 rtl/pipe_hazard_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush scheduler for the 5-stage integer pipeline.
// It merges load-use hazards, multi-cycle EX operations and taken branches
// into one per-stage stall vector, one bubble strobe and one flush strobe.
// A watchdog bounds multi-cycle waits, and a saturating counter tracks
// stalled cycles.
//
// Strobe semantics: ex_mc_start_i and ex_branch_taken_i are single-cycle
// pulses that are sampled only in RUN. ex_mc_done_i is sampled only in
// MC_WAIT. There is no backpressure: every pulse is consumed in the cycle
// it is presented, or it is dropped.
module pipe_hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 2,   // 1..7
  parameter int MC_TIMEOUT   = 64,  // 2..255
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_reg1_read_i,
  input  logic              id_reg2_read_i,
  input  logic [REG_AW-1:0] id_reg1_addr_i,
  input  logic [REG_AW-1:0] id_reg2_addr_i,
  input  logic              ex_is_load_i,
  input  logic              ex_wd_i,
  input  logic [REG_AW-1:0] ex_wreg_i,
  input  logic              ex_mc_start_i,
  input  logic              ex_mc_done_i,
  input  logic              ex_branch_taken_i,
  output logic [5:0]        stall_o,
  output logic              bubble_o,
  output logic              flush_o,
  output logic              timeout_o,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MC_WAIT = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_UNUSED  = 2'd3
  } state_t;

  // Stall patterns: a load-use hazard holds PC/IF/ID; a multi-cycle op
  // also holds EX.
  localparam logic [5:0] STALL_LU = 6'b000111;
  localparam logic [5:0] STALL_MC = 6'b001111;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [7:0] WD_LAST    = 8'(MC_TIMEOUT - 1);

  state_t            state_q;
  state_t            state_d;
  logic [2:0]        flush_cnt_q;
  logic [7:0]        wd_cnt_q;
  logic              flush_q;
  logic              timeout_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic              load_use_hit;
  logic [5:0]        stall_c;
  logic              bubble_c;
  logic              flush_load;
  logic              flush_dec;
  logic              wd_clr;
  logic              wd_inc;
  logic              set_timeout;

  // Load-use hazard: the ID stage reads the register that a load in EX is
  // about to write. Register 0 is hardwired to zero, so it never conflicts.
  always_comb begin
    load_use_hit = 1'b0;
    if (ex_is_load_i && ex_wd_i && (ex_wreg_i != '0)) begin
      load_use_hit = (id_reg1_read_i && (id_reg1_addr_i == ex_wreg_i)) ||
                     (id_reg2_read_i && (id_reg2_addr_i == ex_wreg_i));
    end
  end

  // Next-state logic and combinational stall/bubble outputs.
  always_comb begin
    state_d     = state_q;
    stall_c     = 6'b000000;
    bubble_c    = 1'b0;
    flush_load  = 1'b0;
    flush_dec   = 1'b0;
    wd_clr      = 1'b0;
    wd_inc      = 1'b0;
    set_timeout = 1'b0;
    case (state_q)
      ST_RUN: begin
        // Priority is branch > mc_start > load-use. On a branch, the
        // instruction in ID is squashed, so its hazards do not matter.
        if (ex_branch_taken_i) begin
          state_d    = ST_FLUSH;
          flush_load = 1'b1;
        end else if (ex_mc_start_i) begin
          state_d = ST_MC_WAIT;
          wd_clr  = 1'b1;
          stall_c = STALL_MC;
        end else if (load_use_hit) begin
          stall_c  = STALL_LU;
          bubble_c = 1'b1;
        end
      end
      ST_MC_WAIT: begin
        stall_c = STALL_MC;
        wd_inc  = 1'b1;
        // If done and expiry arrive together, done wins.
        if (ex_mc_done_i) begin
          state_d = ST_RUN;
        end else if (wd_cnt_q == WD_LAST) begin
          state_d     = ST_FLUSH;
          set_timeout = 1'b1;
          flush_load  = 1'b1;
        end
      end
      ST_FLUSH: begin
        flush_dec = 1'b1;
        if (flush_cnt_q <= 3'd1) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    if (rst) begin
      stall_c  = 6'b000000;
      bubble_c = 1'b0;
    end
  end

  // State register, flush/watchdog counters, sticky timeout, and the
  // registered flush strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 3'd0;
      wd_cnt_q    <= 8'd0;
      flush_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= (state_d == ST_FLUSH);
      if (flush_load) begin
        flush_cnt_q <= FLUSH_LOAD;
      end else if (flush_dec && (flush_cnt_q != 3'd0)) begin
        flush_cnt_q <= flush_cnt_q - 3'd1;
      end
      if (wd_clr) begin
        wd_cnt_q <= 8'd0;
      end else if (wd_inc) begin
        wd_cnt_q <= wd_cnt_q + 8'd1;
      end
      if (set_timeout) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if ((stall_c != 6'b000000) && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_o     = stall_c;
  assign bubble_o    = bubble_c;
  assign flush_o     = flush_q;
  assign timeout_o   = timeout_q;
  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios followed by random
// traffic, all checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int REG_AW       = 5;
  localparam int FLUSH_CYCLES = 2;
  localparam int MC_TIMEOUT   = 16;
  localparam int CNT_W        = 5;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  // Clock and reset.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              r1_rd, r2_rd;
  logic [REG_AW-1:0] a1, a2, wreg;
  logic              is_load, wd, mc_start, mc_done, br;
  logic [5:0]        stall;
  logic              bubble, flush, timeout;
  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;

  pipe_hazard_ctrl #(
    .REG_AW(REG_AW), .FLUSH_CYCLES(FLUSH_CYCLES),
    .MC_TIMEOUT(MC_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .id_reg1_read_i(r1_rd), .id_reg2_read_i(r2_rd),
    .id_reg1_addr_i(a1), .id_reg2_addr_i(a2),
    .ex_is_load_i(is_load), .ex_wd_i(wd), .ex_wreg_i(wreg),
    .ex_mc_start_i(mc_start), .ex_mc_done_i(mc_done),
    .ex_branch_taken_i(br),
    .stall_o(stall), .bubble_o(bubble), .flush_o(flush),
    .timeout_o(timeout), .state_o(state), .stall_cnt_o(cnt)
  );

  int n_vec  = 0;
  int n_chk  = 0;
  int n_miss = 0;

  // Behavioural model. The pipeline is running, waiting on a multi-cycle
  // op, or squashing for a number of remaining cycles.
  int m_mode        = 0;  // 0 running, 1 waiting, 2 squashing
  int m_flush_left  = 0;
  int m_waited      = 0;
  int m_timeout     = 0;
  int m_cnt         = 0;

  // Scoreboard of expected combinational outputs for the current cycle.
  logic [5:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit lu_hit();
    return is_load && wd && (wreg != 0) &&
           ((r1_rd && a1 == wreg) || (r2_rd && a2 == wreg));
  endfunction

  // Driver: apply the currently set inputs for one clock cycle and check
  // every output against the model in the middle of the cycle.
  task automatic cycle();
    logic [5:0] e_stall;
    logic       e_bub;
    @(negedge clk);
    #1;
    e_stall = 6'b0;
    e_bub   = 1'b0;
    if (!rst) begin
      if (m_mode == 0) begin
        if (br) e_stall = 6'b0;
        else if (mc_start) e_stall = 6'b001111;
        else if (lu_hit()) begin e_stall = 6'b000111; e_bub = 1'b1; end
      end else if (m_mode == 1) begin
        e_stall = 6'b001111;
      end
    end
    exp_q.push_back(e_stall);
    check("stall", 32'(stall), 32'(exp_q.pop_front()));
    check("bubble", 32'(bubble), 32'(e_bub));
    check("flush", 32'(flush), 32'(m_mode == 2));
    check("timeout", 32'(timeout), 32'(m_timeout));
    check("state", 32'(state), 32'(m_mode));
    check("stall_cnt", 32'(cnt), 32'(m_cnt));
    @(posedge clk);
    n_vec++;
    if (rst) begin
      m_mode = 0; m_flush_left = 0; m_waited = 0; m_timeout = 0; m_cnt = 0;
    end else begin
      if (e_stall != 0 && m_cnt < CNT_MAX) m_cnt++;
      case (m_mode)
        0: begin
          if (br) begin m_mode = 2; m_flush_left = FLUSH_CYCLES; end
          else if (mc_start) begin m_mode = 1; m_waited = 0; end
        end
        1: begin
          m_waited++;
          if (mc_done) m_mode = 0;
          else if (m_waited == MC_TIMEOUT) begin
            m_timeout = 1; m_mode = 2; m_flush_left = FLUSH_CYCLES;
          end
        end
        default: begin
          m_flush_left--;
          if (m_flush_left == 0) m_mode = 0;
        end
      endcase
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; r1_rd = 0; r2_rd = 0; a1 = 0; a2 = 0; wreg = 0;
    is_load = 0; wd = 0; mc_start = 0; mc_done = 0; br = 0;
  endtask

  task automatic idle_cycles(input int n);
    idle();
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    idle(); rst = 1; cycle(); rst = 0;
  endtask

  task automatic set_lu(input logic [REG_AW-1:0] w);
    is_load = 1; wd = 1; wreg = w; r1_rd = 1; a1 = w;
  endtask

  initial begin
    idle();
    rst = 1; cycle(); cycle();
    idle();
    check("reset_state", 32'(state), 32'd0);
    check("reset_cnt", 32'(cnt), 32'd0);

    // Load-use hit on r5: one cycle of stall and bubble.
    set_lu(5'd5); cycle();
    idle(); cycle();
    check("lu_cnt", 32'(cnt), 32'd1);
    // r0 never hazards.
    set_lu(5'd0); cycle();
    idle(); cycle();
    check("lu_r0_cnt", 32'(cnt), 32'd1);
    // Hit through source 2 only.
    is_load = 1; wd = 1; wreg = 5'd9; r2_rd = 1; a2 = 5'd9; r1_rd = 1; a1 = 5'd3;
    cycle();
    idle(); cycle();

    // Taken branch: states 0,2,2,0.
    br = 1; cycle();
    idle();
    check("br_state1", 32'(state), 32'd2);
    cycle();
    check("br_state2", 32'(state), 32'd2);
    cycle();
    check("br_state3", 32'(state), 32'd0);
    idle_cycles(2);

    // Multi-cycle op finishing 10 cycles after start: 11 stalled cycles.
    do_reset();
    mc_start = 1; cycle();
    idle_cycles(9);
    mc_done = 1; cycle();
    idle(); cycle();
    check("mc_cnt", 32'(cnt), 32'd11);
    check("mc_state", 32'(state), 32'd0);

    // Watchdog expiry, flush, return to run with timeout held.
    do_reset();
    mc_start = 1; cycle();
    idle_cycles(MC_TIMEOUT);
    check("to_set", 32'(timeout), 32'd1);
    check("to_flush", 32'(flush), 32'd1);
    idle_cycles(FLUSH_CYCLES + 3);
    check("to_sticky", 32'(timeout), 32'd1);
    check("to_run", 32'(state), 32'd0);

    // Branch, mc_start and load-use together: only the flush is taken.
    do_reset();
    br = 1; mc_start = 1; set_lu(5'd7); cycle();
    idle();
    check("sim_state", 32'(state), 32'd2);
    check("sim_cnt", 32'(cnt), 32'd0);
    idle_cycles(3);

    // Done and watchdog expiry in the same cycle: done wins.
    mc_start = 1; cycle();
    idle_cycles(MC_TIMEOUT - 1);
    mc_done = 1; cycle();
    idle();
    check("race_state", 32'(state), 32'd0);
    check("race_timeout", 32'(timeout), 32'd0);

    // Reset while waiting.
    mc_start = 1; cycle();
    idle_cycles(3);
    rst = 1; cycle(); rst = 0;
    check("rst_mid_state", 32'(state), 32'd0);
    check("rst_mid_cnt", 32'(cnt), 32'd0);
    cycle();

    // Counter saturation.
    for (int k = 0; k < 3; k++) begin
      mc_start = 1; cycle();
      idle_cycles(MC_TIMEOUT + FLUSH_CYCLES + 1);
    end
    check("sat_cnt", 32'(cnt), 32'(CNT_MAX));
    mc_start = 1; cycle();
    idle_cycles(4);
    check("sat_hold", 32'(cnt), 32'(CNT_MAX));

    // Random traffic with a small register space, to make hits likely.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      r1_rd    = 1'($urandom_range(0, 1));
      r2_rd    = 1'($urandom_range(0, 1));
      a1       = REG_AW'($urandom_range(0, 3));
      a2       = REG_AW'($urandom_range(0, 3));
      wreg     = REG_AW'($urandom_range(0, 3));
      is_load  = 1'($urandom_range(0, 1));
      wd       = ($urandom_range(0, 3) != 0);
      mc_start = ($urandom_range(0, 15) == 0);
      mc_done  = ($urandom_range(0, 11) == 0);
      br       = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
